// File: rtl/ora.sv
// ora: output response analyser. Compacts a fixed number of CUT response
// words into a MISR signature after a configurable flush delay, then flags
// whether the final signature matches the expected golden value.
module ora #(
    parameter int                 IN_BITS    = 4,
    parameter logic [IN_BITS-1:0] POLY       = IN_BITS'(4'b0011),
    parameter int                 N_PATTERNS = 15,
    parameter int                 LATENCY    = 2,
    parameter logic [IN_BITS-1:0] GOLDEN     = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               resp_en,
    input  logic [IN_BITS-1:0] resp,
    output logic [IN_BITS-1:0] signature,
    output logic               busy,
    output logic               done,
    output logic               pass
);

    localparam int CNT_W = $clog2(N_PATTERNS + 1);
    localparam logic [CNT_W-1:0] PAT_LAST   = CNT_W'(N_PATTERNS - 1);
    localparam logic [3:0]       FLUSH_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLUSH   = 2'd1,
        S_COMPACT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IN_BITS-1:0] r_sig;
    logic [IN_BITS-1:0] w_sig_nxt;
    logic [IN_BITS-1:0] w_misr;
    logic               r_pass;
    logic               w_pass_nxt;
    logic [3:0]         r_flush_cnt;
    logic [3:0]         w_flush_nxt;
    logic [CNT_W-1:0]   r_pat_cnt;
    logic [CNT_W-1:0]   w_pat_nxt;

    // One MISR step: shift left, fold the MSB back through the taps, XOR in
    // the response. Pure XOR arithmetic, nothing carries between bits.
    function automatic logic [IN_BITS-1:0] misr_step(
        input logic [IN_BITS-1:0] s,
        input logic [IN_BITS-1:0] r
    );
        logic f;
        f = s[IN_BITS-1];
        return (s << 1) ^ (POLY & {IN_BITS{f}}) ^ r;
    endfunction

    assign w_misr = misr_step(r_sig, resp);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Signature, pass flag and counters; all cleared by reset so an abandoned
    // run leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sig       <= '0;
            r_pass      <= 1'b0;
            r_flush_cnt <= 4'd0;
            r_pat_cnt   <= '0;
        end else begin
            r_sig       <= w_sig_nxt;
            r_pass      <= w_pass_nxt;
            r_flush_cnt <= w_flush_nxt;
            r_pat_cnt   <= w_pat_nxt;
        end
    end

    // Next-state and datapath update; start is honoured only when not busy.
    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_pass_nxt  = r_pass;
        w_flush_nxt = r_flush_cnt;
        w_pat_nxt   = r_pat_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_sig_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                    w_flush_nxt = 4'd0;
                    w_pat_nxt   = '0;
                    w_state_nxt = (LATENCY > 0) ? S_FLUSH : S_COMPACT;
                end
            end
            S_FLUSH: begin
                // Discard cycles while the first pattern travels through the
                // TPG register and the CUT.
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_flush_nxt = 4'd0;
                    w_state_nxt = S_COMPACT;
                end else begin
                    w_flush_nxt = r_flush_cnt + 4'd1;
                end
            end
            S_COMPACT: begin
                if (resp_en) begin
                    w_sig_nxt = w_misr;
                    w_pat_nxt = r_pat_cnt + CNT_W'(1);
                    if (r_pat_cnt == PAT_LAST) begin
                        w_state_nxt = S_DONE;
                        w_pass_nxt  = (w_misr == GOLDEN);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign signature = r_sig;
    assign busy      = (r_state == S_FLUSH) || (r_state == S_COMPACT);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;

endmodule

// File: tb/tb_ora.sv
// tb_ora: directed bench for ora with three parameterisations: the default
// configuration, a 4-pattern zero-latency run and a 5-pattern run with a
// non-zero golden signature.
module tb_ora;

    logic       clk;
    logic       rst;

    logic       start0, en0;
    logic [3:0] resp0, sig0;
    logic       busy0, done0, pass0;

    logic       start1, en1;
    logic [3:0] resp1, sig1, sig2;
    logic       busy1, done1, pass1;
    logic       busy2, done2, pass2;

    int n_chk;
    int n_err;

    ora u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .resp_en(en0), .resp(resp0),
        .signature(sig0), .busy(busy0), .done(done0), .pass(pass0)
    );

    ora #(.N_PATTERNS(4), .LATENCY(0), .GOLDEN(4'h0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .resp_en(en1), .resp(resp1),
        .signature(sig1), .busy(busy1), .done(done1), .pass(pass1)
    );

    ora #(.N_PATTERNS(5), .LATENCY(0), .GOLDEN(4'h3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start1), .resp_en(en1), .resp(resp1),
        .signature(sig2), .busy(busy2), .done(done2), .pass(pass2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       en;
        logic [3:0] rs;
        logic [3:0] s1;
        logic       b1, d1, p1;
        logic [3:0] s2;
        logic       b2, d2, p2;
    } vec_t;

    vec_t tbl [0:8];

    // Reference MISR for x^4+x+1, written as the textbook shift register.
    function automatic logic [3:0] misr(input logic [3:0] s, input logic [3:0] r);
        logic [3:0] n;
        n[0] = s[3] ^ r[0];
        n[1] = s[0] ^ s[3] ^ r[1];
        n[2] = s[1] ^ r[2];
        n[3] = s[2] ^ r[3];
        return n;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full run on the default instance. Start is held high through the
    // flush cycles (must be ignored) and resp is 4'hF there (must be ignored).
    task automatic run0(input bit idx_resp, input int stall_at,
                        output int nbusy, output logic [3:0] fsig);
        logic [3:0] exp;
        logic [3:0] r;
        nbusy  = 0;
        start0 = 1'b1; en0 = 1'b0; resp0 = 4'h0;
        step();
        if (busy0) nbusy++;
        chk("start_clear_sig", 32'(sig0), 32'h0);
        chk("start_clear_pass", 32'(pass0), 32'h0);
        for (int e = 0; e < 2; e++) begin
            start0 = 1'b1; en0 = 1'b1; resp0 = 4'hF;
            step();
            if (busy0) nbusy++;
            chk("flush_hold", 32'(sig0), 32'h0);
        end
        start0 = 1'b0;
        exp    = 4'h0;
        for (int p = 0; p < 15; p++) begin
            if (p == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    en0 = 1'b0; resp0 = 4'hF;
                    step();
                    if (busy0) nbusy++;
                    chk("stall_hold", 32'(sig0), 32'(exp));
                end
            end
            r     = idx_resp ? 4'(p + 1) : 4'h0;
            en0   = 1'b1;
            resp0 = r;
            exp   = misr(exp, r);
            step();
            if (busy0) nbusy++;
        end
        en0 = 1'b0; resp0 = 4'h0;
        chk("run_sig", 32'(sig0), 32'(exp));
        chk("run_done", 32'(done0), 32'h1);
        chk("run_pass", 32'(pass0), 32'(exp == 4'h0));
        fsig = sig0;
    endtask

    initial begin
        int         nb;
        logic [3:0] sa, sb, sc;

        n_chk = 0; n_err = 0;
        rst = 1'b0;
        start0 = 1'b0; en0 = 1'b0; resp0 = 4'h0;
        start1 = 1'b0; en1 = 1'b0; resp1 = 4'h0;

        tbl[0] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 4'hF, 4'h8, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0};

        // Reset state, with start held high: must not leave IDLE
        start0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sig", 32'(sig0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_done", 32'(done0), 32'h0);
        chk("rst_pass", 32'(pass0), 32'h0);
        start0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("idle_busy", 32'(busy0), 32'h0);

        // Table-driven runs on the zero-latency instances
        for (int i = 0; i < 9; i++) begin
            start1 = tbl[i].st; en1 = tbl[i].en; resp1 = tbl[i].rs;
            step();
            chk($sformatf("v%0d_sig1", i),  32'(sig1),  32'(tbl[i].s1));
            chk($sformatf("v%0d_busy1", i), 32'(busy1), 32'(tbl[i].b1));
            chk($sformatf("v%0d_done1", i), 32'(done1), 32'(tbl[i].d1));
            chk($sformatf("v%0d_pass1", i), 32'(pass1), 32'(tbl[i].p1));
            chk($sformatf("v%0d_sig2", i),  32'(sig2),  32'(tbl[i].s2));
            chk($sformatf("v%0d_busy2", i), 32'(busy2), 32'(tbl[i].b2));
            chk($sformatf("v%0d_done2", i), 32'(done2), 32'(tbl[i].d2));
            chk($sformatf("v%0d_pass2", i), 32'(pass2), 32'(tbl[i].p2));
        end
        start1 = 1'b0; en1 = 1'b0; resp1 = 4'h0;

        // Asynchronous reset mid-COMPACT, checked before any clock edge
        rst = 1'b0;
        #1;
        chk("arst_sig1", 32'(sig1), 32'h0);
        chk("arst_busy1", 32'(busy1), 32'h0);
        chk("arst_done1", 32'(done1), 32'h0);
        chk("arst_sig2", 32'(sig2), 32'h0);
        chk("arst_busy2", 32'(busy2), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Default instance: 15 zero responses, golden 0
        run0(1'b0, -1, nb, sa);
        chk("busy_cycles_a", 32'(nb), 32'd17);
        chk("final_sig_a", 32'(sa), 32'h0);
        for (int h = 0; h < 2; h++) begin
            en0 = 1'b1; resp0 = 4'hF;
            step();
            chk("done_hold_sig", 32'(sig0), 32'h0);
            chk("done_hold_done", 32'(done0), 32'h1);
            chk("done_hold_pass", 32'(pass0), 32'h1);
        end
        en0 = 1'b0; resp0 = 4'h0;

        // Non-zero responses, unstalled then stalled for 3 cycles mid-run
        run0(1'b1, -1, nb, sb);
        chk("busy_cycles_b", 32'(nb), 32'd17);
        run0(1'b1, 7, nb, sc);
        chk("busy_cycles_c", 32'(nb), 32'd20);
        chk("stall_same_sig", 32'(sc), 32'(sb));

        // Reset during COMPACT on the default instance abandons the run
        start0 = 1'b1;
        step();
        start0 = 1'b0; en0 = 1'b1; resp0 = 4'h7;
        repeat (5) step();
        chk("pre_rst_busy", 32'(busy0), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_sig", 32'(sig0), 32'h0);
        chk("mid_rst_busy", 32'(busy0), 32'h0);
        chk("mid_rst_done", 32'(done0), 32'h0);
        chk("mid_rst_pass", 32'(pass0), 32'h0);
        start0 = 1'b1;
        step();
        chk("rst_start_ignored", 32'(busy0), 32'h0);
        start0 = 1'b0; en0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_idle", 32'(busy0), 32'h0);
        chk("post_rst_done", 32'(done0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
